// File: rtl/ysyx_24100029_ifu.sv
// Instruction fetch unit: one outstanding AXI4-Lite read at a time, result
// handed to decode over a valid/ready handshake, with redirect/squash support.
module ysyx_24100029_ifu #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter logic [1:0]  OKAY_RESP = 2'b00
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic        master_valid,
  input  logic        master_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        inst_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {S_RST, S_REQ, S_WAIT, S_OUT} state_t;

  state_t      r_state;
  logic [31:0] r_next_pc;
  logic [31:0] r_req_addr;
  logic        r_drop;
  logic [31:0] r_inst;
  logic [31:0] r_pc;
  logic        r_fault;
  logic [31:0] w_redir_pc;

  assign w_redir_pc = redirect_pc & ~32'h3;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_RST;
      r_next_pc  <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_drop     <= 1'b0;
      r_inst     <= '0;
      r_pc       <= '0;
      r_fault    <= 1'b0;
    end else begin
      unique case (r_state)
        S_RST: begin
          if (redirect_valid) begin
            r_req_addr <= w_redir_pc;
            r_next_pc  <= w_redir_pc;
          end else begin
            r_req_addr <= r_next_pc;
          end
          r_state <= S_REQ;
        end
        S_REQ: begin
          // A redirect cannot cancel a presented address; mark its response stale.
          if (redirect_valid) begin
            r_next_pc <= w_redir_pc;
            r_drop    <= 1'b1;
          end
          if (arready) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (rvalid) begin
            if (r_drop || redirect_valid) begin
              r_req_addr <= redirect_valid ? w_redir_pc : r_next_pc;
              r_next_pc  <= redirect_valid ? w_redir_pc : r_next_pc;
              r_drop     <= 1'b0;
              r_state    <= S_REQ;
            end else begin
              r_inst    <= rdata;
              r_pc      <= r_req_addr;
              r_fault   <= (rresp != OKAY_RESP);
              r_next_pc <= r_req_addr + 32'd4;
              r_state   <= S_OUT;
            end
          end else if (redirect_valid) begin
            r_next_pc <= w_redir_pc;
            r_drop    <= 1'b1;
          end
        end
        S_OUT: begin
          if (redirect_valid) begin
            r_req_addr <= w_redir_pc;
            r_next_pc  <= w_redir_pc;
            r_state    <= S_REQ;
          end else if (master_ready) begin
            r_req_addr <= r_next_pc;
            r_state    <= S_REQ;
          end
        end
        default: r_state <= S_RST;
      endcase
    end
  end

  assign araddr       = r_req_addr;
  assign arvalid      = (r_state == S_REQ);
  assign rready       = (r_state == S_WAIT);
  assign master_valid = (r_state == S_OUT);
  assign inst         = r_inst;
  assign pc           = r_pc;
  assign inst_fault   = r_fault;

endmodule

// File: tb/tb_ysyx_24100029_ifu.sv
// Self-checking bench for ysyx_24100029_ifu: directed scenarios followed by
// randomized traffic checked against a transaction-level fetch model.
module tb_ysyx_24100029_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [1:0]  OKAY     = 2'b00;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic        master_valid, master_ready;
  logic [31:0] inst, pc;
  logic        inst_fault;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  ysyx_24100029_ifu #(.RESET_PC(RESET_PC), .OKAY_RESP(OKAY)) dut (
    .clock(clock), .reset(reset),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .master_valid(master_valid), .master_ready(master_ready),
    .inst(inst), .pc(pc), .inst_fault(inst_fault),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: packets that must reach decode, and the address of the next read.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } pkt_t;

  pkt_t        q[$];
  logic [31:0] m_ar_addr;
  logic [31:0] m_cur;
  logic [31:0] m_redir;
  logic        m_dirty;

  // Memory responder state.
  logic        mem_busy;
  int          mem_cnt;
  int          nx_lat;
  logic [31:0] nx_data;
  logic [1:0]  nx_resp;

  task automatic model_reset();
    q.delete();
    m_ar_addr = RESET_PC;
    m_cur     = '0;
    m_redir   = '0;
    m_dirty   = 1'b0;
    mem_busy  = 1'b0;
    mem_cnt   = 0;
  endtask

  // Called at a falling edge: drive inputs for this cycle, check, update model,
  // then advance to the next falling edge.
  task automatic step(input logic ar, input logic mr, input logic rv, input logic [31:0] rpc);
    logic [31:0] tpc;
    pkt_t        p;
    arready        = ar;
    master_ready   = mr;
    redirect_valid = rv;
    redirect_pc    = rpc;
    rvalid         = mem_busy && (mem_cnt == 0);
    rdata          = rvalid ? nx_data : $urandom;
    rresp          = rvalid ? nx_resp : 2'b11;
    tpc            = {rpc[31:2], 2'b00};

    chk("one_hot", 32'(arvalid) + 32'(rready) + 32'(master_valid) <= 32'd1 ? 32'd1 : 32'd0, 32'd1);
    chk("mvalid", 32'(master_valid), 32'(q.size() != 0));
    if (arvalid) begin
      chk("araddr", araddr, m_ar_addr);
      chk("ar_outstanding", 32'(mem_busy), 32'd0);
    end
    if (rvalid) chk("rready", 32'(rready), 32'd1);
    if (master_valid && q.size() != 0) begin
      chk("inst", inst, q[0].inst);
      chk("pc", pc, q[0].pc);
      chk("fault", 32'(inst_fault), 32'(q[0].fault));
    end

    if (rvalid && rready) begin
      if (m_dirty || rv) begin
        m_ar_addr = rv ? tpc : m_redir;
        m_dirty   = 1'b0;
      end else begin
        p.pc = m_cur; p.inst = rdata; p.fault = (rresp != OKAY);
        q.push_back(p);
        m_ar_addr = m_cur + 32'd4;
      end
    end else if (rv && (arvalid || rready)) begin
      m_dirty = 1'b1;
      m_redir = tpc;
    end
    if (master_valid && q.size() != 0) begin
      if (rv) begin
        m_ar_addr = tpc;
        void'(q.pop_front());
      end else if (mr) begin
        void'(q.pop_front());
      end
    end

    if (rvalid) mem_busy = 1'b0;
    else if (mem_busy && mem_cnt != 0) mem_cnt--;
    if (arvalid && arready) begin
      m_cur    = m_ar_addr;
      mem_busy = 1'b1;
      mem_cnt  = nx_lat;
    end
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    arready = 1'b0; master_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    rvalid = 1'b0; rdata = '0; rresp = '0;
    nx_lat = 0; nx_data = '0; nx_resp = OKAY;
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b0;

    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_fault", 32'(inst_fault), 32'd0);
    step(1'b0, 1'b0, 1'b0, '0);

    // First fetch with zero-wait memory.
    nx_data = 32'h0000_0413;
    chk("t1_arvalid", 32'(arvalid), 32'd1);
    chk("t1_araddr", araddr, 32'h8000_0000);
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    chk("t1_mvalid", 32'(master_valid), 32'd1);
    chk("t1_inst", inst, 32'h0000_0413);
    chk("t1_pc", pc, 32'h8000_0000);
    step(1'b1, 1'b1, 1'b0, '0);
    chk("t1_next_araddr", araddr, 32'h8000_0004);

    // Backpressure in OUT.
    nx_data = 32'h0010_0093;
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_mvalid", 32'(master_valid), 32'd1);
      chk("t2_hold_pc", pc, 32'h8000_0004);
      chk("t2_hold_inst", inst, 32'h0010_0093);
      chk("t2_no_ar", 32'(arvalid), 32'd0);
      step(1'b1, 1'b0, 1'b0, '0);
    end
    step(1'b1, 1'b1, 1'b0, '0);
    chk("t2_next_araddr", araddr, 32'h8000_0008);

    // Faulting response is delivered, fetch continues sequentially.
    nx_resp = 2'b10;
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    chk("t5_fault", 32'(inst_fault), 32'd1);
    chk("t5_pc", pc, 32'h8000_0008);
    step(1'b1, 1'b1, 1'b0, '0);
    chk("t5_next_araddr", araddr, 32'h8000_000C);
    nx_resp = OKAY;

    // Redirect during WAIT squashes the late response.
    nx_lat = 2;
    step(1'b1, 1'b1, 1'b0, '0);
    nx_data = 32'hDEAD_BEEF;
    step(1'b1, 1'b1, 1'b1, 32'h8000_0100);
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    chk("t3_no_mvalid", 32'(master_valid), 32'd0);
    chk("t3_araddr", araddr, 32'h8000_0100);

    // Reset during WAIT.
    nx_lat = 3;
    step(1'b1, 1'b1, 1'b0, '0);
    chk("t6_in_wait", 32'(rready), 32'd1);
    reset = 1'b1;
    arready = 1'b0; master_ready = 1'b0; redirect_valid = 1'b0; rvalid = 1'b0;
    #1;
    chk("t6_arvalid", 32'(arvalid), 32'd0);
    chk("t6_rready", 32'(rready), 32'd0);
    chk("t6_mvalid", 32'(master_valid), 32'd0);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    nx_lat = 0;
    step(1'b0, 1'b1, 1'b0, '0);
    chk("t6_araddr", araddr, 32'h8000_0000);

    // Redirect in REQ with a stalled address channel; low bits are ignored.
    step(1'b0, 1'b1, 1'b1, 32'h8000_0203);
    chk("t4_stable0", araddr, 32'h8000_0000);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("t4_stable1", araddr, 32'h8000_0000);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("t4_stable2", araddr, 32'h8000_0000);
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    chk("t4_no_mvalid", 32'(master_valid), 32'd0);
    chk("t4_araddr", araddr, 32'h8000_0200);

    // Redirect in OUT to the top word, then wrap to zero.
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    chk("t7_araddr", araddr, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    chk("t7_pc", pc, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, 1'b0, '0);
    chk("t7_wrap", araddr, 32'h0000_0000);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic        rv;
      logic [31:0] rpc;
      nx_lat  = $urandom_range(0, 3);
      nx_data = $urandom;
      nx_resp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : OKAY;
      rv  = (arvalid || rready || master_valid) && ($urandom_range(0, 7) == 0);
      rpc = RESET_PC + 32'($urandom_range(0, 4095));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, rv, rpc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_24100029_ifu.md
Name: ysyx_24100029_ifu

Overview:
- Instruction fetch unit: the producer side of the decode stage's slave_valid/slave_ready + inst/pc interface.
- Holds the fetch PC and issues one 32-bit read at a time on an AXI4-Lite read channel (AR/R only).
- Presents the returned word plus its PC downstream under a valid/ready handshake.
- Accepts redirects (branch/jump/trap/mret) from later stages and squashes stale fetches.

Parameters:
- RESET_PC, 32'h8000_0000, first fetch address after reset.
- OKAY_RESP, 2'b00, rresp value treated as success; any other value flags inst_fault.

Ports:
- clock  input  1  single clock for all state.
- reset  input  1  asynchronous, active-high reset.
- araddr  output  32  read address; equals req_addr register.
- arvalid  output  1  read address valid.
- arready  input  1  read address accepted.
- rdata  input  32  read data (instruction word).
- rresp  input  2  read response.
- rvalid  input  1  read data valid.
- rready  output  1  read data ready.
- master_valid  output  1  inst/pc/inst_fault valid to decode.
- master_ready  input  1  decode accepts the packet.
- inst  output  32  fetched instruction.
- pc  output  32  address of inst.
- inst_fault  output  1  fetch returned rresp != OKAY_RESP; inst = rdata as returned.
- redirect_valid  input  1  single-cycle request to restart fetch.
- redirect_pc  input  32  new fetch target; bits [1:0] forced to 0 internally.

Behaviour:
- Reset (async, active-high) values: state=RST, next_pc=RESET_PC, req_addr=RESET_PC, drop=0, inst=0, pc=0, inst_fault=0.
- Outputs are Moore decodes of state: arvalid=(REQ), rready=(WAIT), master_valid=(OUT). All three are 0 while reset is high.
- States and transitions (redirect has priority over every other transition):
  - RST: always go to REQ; load req_addr=next_pc.
  - REQ: araddr/arvalid held stable until arready; araddr never changes while arvalid=1.
    - arready=1: go to WAIT.
    - redirect_valid=1: next_pc=redirect_pc and drop=1. This also applies in the same cycle as arready. The in-flight request still completes.
  - WAIT: rready=1.
    - redirect_valid=1 with no rvalid: next_pc=redirect_pc, drop=1.
    - rvalid=1 and (drop=1 or redirect_valid=1): discard rdata. Go to REQ with req_addr = (redirect_valid ? redirect_pc : next_pc). Clear drop.
    - rvalid=1, drop=0, no redirect: inst=rdata, pc=req_addr, inst_fault=(rresp!=OKAY_RESP), next_pc=req_addr+4. Go to OUT.
  - OUT: master_valid=1; inst/pc/inst_fault held stable until leaving OUT.
    - redirect_valid=1: go to REQ with req_addr=redirect_pc, next_pc=redirect_pc. This applies whether or not master_ready is high that cycle; the consumer's flush handles a simultaneous handshake.
    - master_ready=1, no redirect: go to REQ with req_addr=next_pc.
    - Otherwise hold (backpressure, unbounded).
- At most one outstanding read. Throughput is one instruction per 3 cycles with zero-wait memory.
- A fault is not sticky: after delivering a faulting packet, fetch continues at pc+4 until a redirect arrives.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- A redirect and rvalid in the same WAIT cycle never deliver the data.
- Multiple redirects before the response arrives: the last one wins.
- Reset asserted mid-transaction returns to RST immediately. No response is tracked across reset; the memory side is reset by the same signal.

Test Plan:
- Reset release, arready=1 immediately, rdata=32'h00000413, rvalid one cycle after AR -> araddr=0x80000000, then master_valid=1 with inst=0x00000413, pc=0x80000000; next araddr=0x80000004.
- master_ready=0 for 5 cycles in OUT -> master_valid, inst and pc stable for 5 cycles; no arvalid issued; after master_ready=1, the next REQ uses pc+4.
- redirect_valid with redirect_pc=0x80000100 during WAIT, rvalid 2 cycles later with 0xDEADBEEF -> the word is never presented; next araddr=0x80000100.
- redirect_pc=0x80000203 during REQ with arready=0 for 3 cycles -> araddr stays 0x80000000 until accepted, response dropped, next araddr=0x80000200.
- rresp=2'b10 on the fetch of 0x80000008 -> master_valid=1, inst_fault=1, pc=0x80000008; next araddr=0x8000000C.
- Assert reset during WAIT, then release -> arvalid/rready/master_valid go to 0 asynchronously; first araddr after release is 0x80000000.
